// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: unit mode encoding, FSM states and
// the step-count width derivation.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_SHR_SI = 3'd2,
    OP_SHL_SI = 3'd3,
    OP_ROR    = 3'd4,
    OP_ROL    = 3'd5,
    OP_ASR    = 3'd6,
    OP_SHL_Z  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_STEP = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // One extra bit so a count of N (full rotation) is representable.
  function automatic int cw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int N_DEFAULT  = 8;
  localparam int CW_DEFAULT = cw_of(N_DEFAULT);

endpackage

// File: rtl/seq_step_counter.sv
// Loadable down-counter for the step phase; flags zero and the final step.
module seq_step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for the universal shift unit: load operand, apply
// one mode for a programmed number of cycles, return the register contents.
//
// state | meaning
// CLR   | unit held in clear, no handshakes
// IDLE  | waiting for a command
// LOAD  | unit loads the latched operand
// STEP  | unit applies the latched mode, one update per cycle
// RESP  | result presented, unit holds
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_serial_in,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          busy,
  output logic [2:0]    fu_sel,
  output logic [N-1:0]  fu_data_in,
  output logic          fu_msb_in,
  output logic          fu_lsb_in,
  output logic          fu_rst,
  input  logic [N-1:0]  fu_data_out
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [N-1:0]  data_q;
  logic          serial_q;
  logic          accept;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          cnt_last;
  logic [CW-1:0] cnt_load_val;
  op_e           sel;

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  // A LOAD command never steps, whatever count came with it.
  assign cnt_load_val = (op_e'(cmd_op) == OP_LOAD) ? '0 : cmd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLR;
      op_q     <= OP_HOLD;
      data_q   <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        data_q   <= cmd_data;
        serial_q <= cmd_serial_in;
      end
    end
  end

  seq_step_counter #(.CW(CW)) u_step_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    fu_rst    = 1'b0;
    sel       = OP_HOLD;
    cnt_dec   = 1'b0;
    unique case (state_q)
      ST_CLR: begin
        fu_rst  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sel     = OP_LOAD;
        state_d = (cnt_zero || op_q == OP_LOAD) ? ST_RESP : ST_STEP;
      end
      ST_STEP: begin
        sel     = op_q;
        cnt_dec = 1'b1;
        if (cnt_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLR;
      end
    endcase
  end

  assign fu_sel     = sel;
  assign fu_data_in = data_q;
  assign fu_msb_in  = serial_q;
  assign fu_lsb_in  = serial_q;
  assign rsp_data   = fu_data_out;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 8-bit universal
// shift unit closing the loop on fu_* signals.
module tb_shift_sequencer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  cmd_data;
  logic          cmd_serial_in;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          busy;
  logic [2:0]    fu_sel;
  logic [N-1:0]  fu_data_in;
  logic          fu_msb_in;
  logic          fu_lsb_in;
  logic          fu_rst;
  logic [N-1:0]  fu_data_out;

  shift_sequencer #(.N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_count     (cmd_count),
    .cmd_data      (cmd_data),
    .cmd_serial_in (cmd_serial_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .fu_sel        (fu_sel),
    .fu_data_in    (fu_data_in),
    .fu_msb_in     (fu_msb_in),
    .fu_lsb_in     (fu_lsb_in),
    .fu_rst        (fu_rst),
    .fu_data_out   (fu_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Functional unit model
  logic [N-1:0] fu_q;
  always @(posedge clk) begin
    if (fu_rst) fu_q <= '0;
    else begin
      case (fu_sel)
        3'd0: fu_q <= fu_q;
        3'd1: fu_q <= fu_data_in;
        3'd2: fu_q <= {fu_msb_in, fu_q[N-1:1]};
        3'd3: fu_q <= {fu_q[N-2:0], fu_lsb_in};
        3'd4: fu_q <= {fu_q[0], fu_q[N-1:1]};
        3'd5: fu_q <= {fu_q[N-2:0], fu_q[N-1]};
        3'd6: fu_q <= {fu_q[N-1], fu_q[N-1:1]};
        default: fu_q <= {fu_q[N-2:0], 1'b0};
      endcase
    end
  end
  assign fu_data_out = fu_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [N-1:0] data;
    int           lat;
    int           hs;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: new response -> pop and compare data and latency; held response -> stability
  logic         in_rsp = 1'b0;
  logic [N-1:0] cur_data;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_data), 32'hDEAD);
          cur_data = rsp_data;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          cur_data = e.data;
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_latency", 32'(cyc - e.hs), 32'(e.lat));
        end
      end else begin
        chk("rsp_hold", 32'(rsp_data), 32'(cur_data));
      end
      if (rsp_ready) in_rsp = 1'b0;
    end else begin
      in_rsp = 1'b0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [N-1:0] data,
                      input logic ser, input bit expect_rsp, input logic [N-1:0] exp_data,
                      input int exp_lat);
    int guard;
    bit ok;
    exp_t e;
    guard = 0;
    ok = 1'b0;
    cmd_op = op;
    cmd_count = cnt;
    cmd_data = data;
    cmd_serial_in = ser;
    cmd_valid = 1'b1;
    while (guard < 60) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      guard++;
    end
    if (!ok) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (expect_rsp) begin
      e.data = exp_data;
      e.lat  = exp_lat;
      e.hs   = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || rsp_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_count = '0;
    cmd_data = '0;
    cmd_serial_in = 1'b0;
    rsp_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_fu_rst", 32'(fu_rst), 32'h1);
      chk("rst_fu_sel", 32'(fu_sel), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("clr_fu_rst", 32'(fu_rst), 32'h1);
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("idle_fu_rst", 32'(fu_rst), 32'h0);
    chk("idle_unit_clear", 32'(fu_data_out), 32'h00);

    send(3'd2, 4'd3, 8'hB4, 1'b1, 1, 8'hF6, 4);
    send(3'd5, 4'd9, 8'h81, 1'b0, 1, 8'h03, 10);
    send(3'd7, 4'd1, 8'h81, 1'b0, 1, 8'h02, 2);
    send(3'd6, 4'd2, 8'h90, 1'b0, 1, 8'hE4, 3);
    send(3'd4, 4'd8, 8'h01, 1'b0, 1, 8'h01, 9);
    send(3'd3, 4'd2, 8'hB4, 1'b1, 1, 8'hD3, 3);
    send(3'd4, 4'd0, 8'hA5, 1'b0, 1, 8'hA5, 1);
    drain();

    // LOAD with a count, under response backpressure
    rsp_ready = 1'b0;
    send(3'd1, 4'd5, 8'h5A, 1'b0, 1, 8'h5A, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        cmd_op = 3'd4;
        cmd_count = 4'd1;
        cmd_data = 8'hFF;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_accept", 32'(cmd_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("bp_ready_after_accept", 32'(cmd_ready), 32'h1);
    chk("bp_rsp_dropped", 32'(rsp_valid), 32'h0);
    drain();

    // Reset during STEP discards the command
    send(3'd2, 4'd7, 8'hAA, 1'b1, 0, 8'h00, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fu_rst", 32'(fu_rst), 32'h1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_unit_clear", 32'(fu_data_out), 32'h00);
    rst_n = 1'b1;
    send(3'd0, 4'd2, 8'h3C, 1'b0, 1, 8'h3C, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller that sequences the N-bit universal shift functional unit. It accepts one command at a time over a valid/ready handshake. For each command it loads an operand into the unit, applies one shift/rotate mode for a programmed number of cycles, and returns the register contents over a valid/ready response channel. It sits between the register/bus-side logic and the functional unit, and is the only driver of the unit's mode select, parallel data, serial inputs and reset.

## Interface
Parameters:
- N, 8, width of the functional unit and of the data paths
- CW, $clog2(N)+1, width of the step count (derived; do not override)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  mode, same encoding as the unit's select (see Operation)
- cmd_count  in  CW  number of mode steps after the load, 0..2^CW-1
- cmd_data  in  N  operand loaded before stepping
- cmd_serial_in  in  1  serial bit for the SHR_SI and SHL_SI modes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumer ready
- rsp_data  out  N  result, equals fu_data_out
- busy  out  1  high in every state except IDLE
- fu_sel  out  3  unit mode select
- fu_data_in  out  N  unit parallel input
- fu_msb_in, fu_lsb_in  out  1 each  unit serial inputs; both driven with the latched serial bit
- fu_rst  out  1  unit synchronous active-high clear
- fu_data_out  in  N  unit register contents

## Operation
- Op encoding:
  - 0 HOLD
  - 1 LOAD
  - 2 SHR_SI: shift right, MSB takes serial bit
  - 3 SHL_SI: shift left, LSB takes serial bit
  - 4 ROR
  - 5 ROL
  - 6 ASR
  - 7 SHL_Z: shift left, zero fill
- FSM states: CLR, IDLE, LOAD, STEP, RESP. The asynchronous reset forces CLR.
- CLR:
  - Outputs: fu_rst=1, fu_sel=HOLD, cmd_ready=0, rsp_valid=0.
  - After one clock with rst_n high, go to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, count, data and serial bit, then go to LOAD.
- LOAD:
  - fu_sel=LOAD, fu_data_in=latched data.
  - Go to STEP if count>0 and op is not LOAD. Otherwise go to RESP. An op of LOAD always uses an effective count of 0.
- STEP:
  - fu_sel=latched op. Decrement the counter each cycle.
  - Leave for RESP on the cycle the counter reaches 1 → 0. This gives exactly count unit updates.
  - HOLD with count k is a k-cycle delay; the result equals cmd_data.
- RESP:
  - fu_sel=HOLD, rsp_valid=1, rsp_data=fu_data_out (stable while held).
  - On rsp_ready, go to IDLE.
- fu_sel=HOLD in CLR, IDLE and RESP. fu_rst=0 outside CLR.
- Counts above N are legal and are not clamped, e.g. ROR by N returns the operand.
- Reset values: cmd_ready=0, rsp_valid=0, busy=1, fu_rst=1, fu_sel=HOLD, latched registers all zero.

## Timing
- Cycle 0 is the handshake edge. The unit loads at edge 1 and steps at edges 2..count+1.
- rsp_valid is asserted in the cycle after edge count+1, i.e. latency count+1 cycles (1 for count 0).
- One command is in flight at a time. cmd_ready=0 from the handshake edge until the edge after the rsp handshake. Minimum period is count+3 cycles.
- cmd_valid during LOAD/STEP/RESP is ignored and not latched.
- Reset asserted mid-command:
  - The command is discarded and rsp_valid drops immediately.
  - fu_rst is asserted asynchronously; the unit clears on the next clk edge while rst_n is low.
- Response backpressure: rsp_data and rsp_valid are held indefinitely; the unit does not change because fu_sel=HOLD.

## Structure
- Package shift_seq_pkg holds:
  - the op enum (3-bit, values above)
  - the FSM state enum
  - a localparam for CW as a function of N
- One natural sub-module: seq_step_counter, a loadable CW-bit down-counter with a zero flag.
- The functional unit is not instantiated inside this block. Integration happens at the parent level.

## Test plan
(N=8 throughout)
- Reset: hold rst_n low for 3 clocks.
  - During reset: fu_rst=1, fu_sel=0, cmd_ready=0, rsp_valid=0.
  - After release, cmd_ready rises after exactly one clock and the unit reads 00.
- SHR_SI, data B4, count 3, serial 1 → rsp_data F6, rsp_valid 4 cycles after the handshake.
- ROL, data 81, count 9 → rsp_data 03. SHL_Z, data 81, count 1 → 02.
- ASR, data 90, count 2 → E4. ROR, data 01, count 8 → 01.
- LOAD, data 5A, count 5, rsp_ready low for 5 cycles:
  - rsp_valid asserts 1 cycle after the handshake.
  - rsp_data stays 5A while rsp_valid is held; a cmd_valid pulse in that window is not accepted.
  - cmd_ready rises the cycle after rsp accept.
- Drop rst_n during STEP of SHR_SI with count 7:
  - rsp_valid is never asserted and fu_rst goes high immediately.
  - After release, a following HOLD with data 3C and count 2 returns 3C in 3 cycles.
